vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator for the FPGA video path. It derives a pixel clock enable from `input_clk` and runs horizontal/vertical position counters for any mode given by front-porch/sync/back-porch parameters, with per-axis sync polarity. Sync and data-enable outputs are delayed by a configurable number of pixel steps, so they line up with a downstream pixel-fetch pipeline driven from the undelayed counters. Its outputs drive the `hsync`/`vsync`/colour pins and the pixel source.

## Interface
Parameters:
- `CLK_DIV`, 2: `input_clk` cycles per pixel, ≥1
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal pixels; H_TOTAL = sum (800)
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 400/12/2/36: vertical lines; V_TOTAL = sum (450)
- `HSYNC_POL`, 0: asserted level of `hsync` (0 = active-low)
- `VSYNC_POL`, 0: asserted level of `vsync`
- `PIPE`, 2: pixel steps of delay on `hsync`/`vsync`/`de`, 1..8
- `POS_W`, 12: counter width; must hold max(H_TOTAL, V_TOTAL)-1

Ports:
- `input_clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  run enable; low freezes all state
- `pix_ce`  out  1  pixel clock enable, one `input_clk` wide
- `hpos`  out  POS_W  current horizontal position, undelayed
- `vpos`  out  POS_W  current line, undelayed
- `fetch_active`  out  1  `hpos<H_ACTIVE && vpos<V_ACTIVE`, undelayed
- `hsync`  out  1  delayed horizontal sync
- `vsync`  out  1  delayed vertical sync
- `de`  out  1  delayed active-video flag
- `line_start`  out  1  one-clock pulse, undelayed, first clock with `hpos==0`
- `frame_start`  out  1  one-clock pulse, undelayed, first clock with `hpos==0 && vpos==0`
- `frame_ctr`  out  8  frames completed, wraps 255→0

## Operation
- Divider `div` counts 0..CLK_DIV-1 while `en`=1. `pix_ce` = `en && div==CLK_DIV-1`, combinational. With CLK_DIV=1, `pix_ce`=`en`.
- On each `pix_ce` edge: if `hpos==H_TOTAL-1`, `hpos`←0 and `vpos` advances (`V_TOTAL-1`→0, which also increments `frame_ctr`). Otherwise `hpos`+1.
- Decode of the pre-update counters:
  - hs_d = `H_ACTIVE+H_FP ≤ hpos < H_ACTIVE+H_FP+H_SYNC`
  - vs_d = `V_ACTIVE+V_FP ≤ vpos < V_ACTIVE+V_FP+V_SYNC`
  - de_d = `fetch_active`
- Delay line of PIPE stages, shifted only on `pix_ce`: stage1 ← decode, stage k ← stage k-1.
  - `hsync` = stage_PIPE.hs ? HSYNC_POL : ~HSYNC_POL
  - `vsync` likewise with VSYNC_POL
  - `de` = stage_PIPE.de
- `line_start` and `frame_start` are registered: they go high the clock after the wrap edge, for exactly one clock.
- `vsync` only changes on line boundaries, because `vpos` only changes on an `hpos` wrap.
- `en` low: `div`, counters, delay line and `frame_ctr` hold; `pix_ce`=0; pulses drop after one clock; outputs hold. Resumes from the exact held phase.
- Reset (asynchronous, any time, including mid-line or mid-sync):
  - `div`, `hpos`, `vpos` = 0; `frame_ctr` = 0
  - all delay stages = not-asserted, so `hsync`=~HSYNC_POL, `vsync`=~VSYNC_POL, `de`=0
  - `line_start`, `frame_start` = 0; no pulse is generated for the reset-time (0,0)
- Counter arithmetic is unsigned POS_W bits. Values ≥ TOTAL are unreachable.

## Timing
- One line = H_TOTAL·CLK_DIV clocks (default 1600). One frame = V_TOTAL lines (default 720000 clocks).
- `hsync` asserts exactly PIPE·CLK_DIV clocks after `hpos` first reads H_ACTIVE+H_FP. It stays asserted H_SYNC·CLK_DIV clocks (default 192).
- `de` is high for H_ACTIVE·CLK_DIV clocks per active line. It lags `fetch_active` by PIPE·CLK_DIV clocks.
- `vsync` asserts for V_SYNC·H_TOTAL·CLK_DIV clocks (default 3200).
- `pix_ce` first asserts CLK_DIV clocks after reset release with `en`=1.
- Output registers update only on `pix_ce` edges; no combinational path from `en` to sync outputs.

## Test plan
- **Reset values:** assert `rst` for 3 clocks → `hsync`=`vsync`=1, `de`=0, `hpos`=`vpos`=0, `frame_ctr`=0, no `frame_start`. Release → `pix_ce` every 2nd clock.
- **Line timing (defaults):** measure the `hsync` low width → 192 clocks. Period → 1600 clocks. Fall occurs 4 clocks after `hpos`=656. `de` high 1280 clocks on lines 0..399, 0 on lines 400..449.
- **Frame timing:** run 2 frames → `vsync` low 3200 clocks, starting at line 412 (+4 clocks). `frame_start` period 720000. `frame_ctr`=2.
- **Parameter sweep:** CLK_DIV=1, PIPE=1, HSYNC_POL=VSYNC_POL=1, tiny mode 8/2/3/1 × 4/1/2/1 → `hsync` high 3 clocks, period 14. `vsync` high 28 clocks. `de` lags `fetch_active` by 1.
- **Enable stall:** drop `en` for 37 clocks mid-hsync → `hsync` pulse width = 192+37, all counters resume contiguous, `line_start` spacing = 1600+37.
- **Async reset mid-frame:** assert `rst` asynchronously at `hpos`=700, `vpos`=413 → outputs return to reset values without waiting for a clock edge. After release, the first `hsync` fall is at 656·2+4 clocks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with counters, sync/de delay line and frame pulses
module vga_timing_gen #(
  parameter int   CLK_DIV   = 2,
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 400,
  parameter int   V_FP      = 12,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 36,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   PIPE      = 2,
  parameter int   POS_W     = 12
) (
  input  logic             input_clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_ce,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             fetch_active,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_ctr
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [POS_W-1:0] H_ACT  = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_ACT  = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] HS_ON  = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] HS_OFF = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] VS_ON  = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] VS_OFF = POS_W'(V_ACTIVE + V_FP + V_SYNC);
  logic [DW-1:0]   div;
  logic [PIPE-1:0] hs_q, vs_q, de_q;
  logic            hs_d, vs_d, h_wrap, v_wrap;
  always_comb begin
    pix_ce       = en && div == D_LAST;
    fetch_active = hpos < H_ACT && vpos < V_ACT;
    hs_d         = hpos >= HS_ON && hpos < HS_OFF;
    vs_d         = vpos >= VS_ON && vpos < VS_OFF;
    h_wrap       = hpos == H_LAST;
    v_wrap       = vpos == V_LAST;
    hsync        = hs_q[PIPE-1] ? HSYNC_POL : ~HSYNC_POL;
    vsync        = vs_q[PIPE-1] ? VSYNC_POL : ~VSYNC_POL;
    de           = de_q[PIPE-1];
  end
  // bit 0 of each delay vector is the first stage; the decode enters there on every pixel step
  always_ff @(posedge input_clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      hpos        <= '0;
      vpos        <= '0;
      frame_ctr   <= '0;
      hs_q        <= '0;
      vs_q        <= '0;
      de_q        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce && h_wrap;
      frame_start <= pix_ce && h_wrap && v_wrap;
      if (en) div <= div == D_LAST ? '0 : div + 1'b1;
      if (pix_ce) begin
        hpos <= h_wrap ? '0 : hpos + 1'b1;
        if (h_wrap) vpos <= v_wrap ? '0 : vpos + 1'b1;
        if (h_wrap && v_wrap) frame_ctr <= frame_ctr + 8'd1;
        hs_q <= PIPE'({hs_q, hs_d});
        vs_q <= PIPE'({vs_q, vs_d});
        de_q <= PIPE'({de_q, fetch_active});
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three configurations checked against an arithmetic raster model plus directed timing sequences
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  longint cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic pce_a, fa_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [11:0] hpos_a, vpos_a;
  logic [7:0] fc_a;
  logic pce_b, fa_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [4:0] hpos_b, vpos_b;
  logic [7:0] fc_b;
  logic pce_c, fa_c, hs_c, vs_c, de_c, ls_c, fs_c;
  logic [3:0] hpos_c, vpos_c;
  logic [7:0] fc_c;

  vga_timing_gen dut_a (
    .input_clk(clk), .rst(rst), .en(en), .pix_ce(pce_a), .hpos(hpos_a), .vpos(vpos_a),
    .fetch_active(fa_a), .hsync(hs_a), .vsync(vs_a), .de(de_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_ctr(fc_a));

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .PIPE(3), .POS_W(5)
  ) dut_b (
    .input_clk(clk), .rst(rst), .en(en), .pix_ce(pce_b), .hpos(hpos_b), .vpos(vpos_b),
    .fetch_active(fa_b), .hsync(hs_b), .vsync(vs_b), .de(de_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_ctr(fc_b));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE(1), .POS_W(4)
  ) dut_c (
    .input_clk(clk), .rst(rst), .en(en), .pix_ce(pce_c), .hpos(hpos_c), .vpos(vpos_c),
    .fetch_active(fa_c), .hsync(hs_c), .vsync(vs_c), .de(de_c), .line_start(ls_c),
    .frame_start(fs_c), .frame_ctr(fc_c));

  typedef struct {
    int d, ha, hf, hs, hb, va, vf, vs, vb, pipe, hp, vp;
  } cfg_t;
  typedef struct {
    logic pce, fa, hs, vs, de, ls, fs;
    logic [11:0] h, v;
    logic [7:0] fc;
  } obs_t;
  typedef struct {
    int en, h, v, hs, de, pce, ls;
  } vec_t;

  cfg_t   cfg[3];
  longint mc[3];
  bit     mls[3], mfs[3];
  string  nm[3] = '{"A", "B", "C"};
  vec_t   tv[17];

  function automatic int ht(int i);
    return cfg[i].ha + cfg[i].hf + cfg[i].hs + cfg[i].hb;
  endfunction

  function automatic int vt(int i);
    return cfg[i].va + cfg[i].vf + cfg[i].vs + cfg[i].vb;
  endfunction

  // raster position is just the pixel-step count folded by line and frame length
  function automatic obs_t model(int i);
    obs_t e;
    cfg_t k;
    longint p, q;
    int h, v, qh, qv;
    k = cfg[i];
    p = mc[i] / k.d;
    q = p - k.pipe;
    h = int'(p % ht(i));
    v = int'((p / ht(i)) % vt(i));
    qh = int'(q % ht(i));
    qv = int'((q / ht(i)) % vt(i));
    e.pce = en && (mc[i] % k.d == k.d - 1);
    e.h = 12'(h);
    e.v = 12'(v);
    e.fc = 8'((p / (ht(i) * vt(i))) % 256);
    e.fa = h < k.ha && v < k.va;
    e.hs = (p >= k.pipe && qh >= k.ha + k.hf && qh < k.ha + k.hf + k.hs) ^ (k.hp == 0);
    e.vs = (p >= k.pipe && qv >= k.va + k.vf && qv < k.va + k.vf + k.vs) ^ (k.vp == 0);
    e.de = p >= k.pipe && qh < k.ha && qv < k.va;
    e.ls = mls[i];
    e.fs = mfs[i];
    return e;
  endfunction

  function automatic obs_t get_obs(int i);
    obs_t o;
    case (i)
      0: begin
        o.pce = pce_a; o.fa = fa_a; o.hs = hs_a; o.vs = vs_a; o.de = de_a;
        o.ls = ls_a; o.fs = fs_a; o.h = hpos_a; o.v = vpos_a; o.fc = fc_a;
      end
      1: begin
        o.pce = pce_b; o.fa = fa_b; o.hs = hs_b; o.vs = vs_b; o.de = de_b;
        o.ls = ls_b; o.fs = fs_b; o.h = 12'(hpos_b); o.v = 12'(vpos_b); o.fc = fc_b;
      end
      default: begin
        o.pce = pce_c; o.fa = fa_c; o.hs = hs_c; o.vs = vs_c; o.de = de_c;
        o.ls = ls_c; o.fs = fs_c; o.h = 12'(hpos_c); o.v = 12'(vpos_c); o.fc = fc_c;
      end
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    obs_t o, e;
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      e = model(i);
      chk({nm[i], ".pix_ce"}, 64'(o.pce), 64'(e.pce));
      chk({nm[i], ".hpos"}, 64'(o.h), 64'(e.h));
      chk({nm[i], ".vpos"}, 64'(o.v), 64'(e.v));
      chk({nm[i], ".fetch_active"}, 64'(o.fa), 64'(e.fa));
      chk({nm[i], ".hsync"}, 64'(o.hs), 64'(e.hs));
      chk({nm[i], ".vsync"}, 64'(o.vs), 64'(e.vs));
      chk({nm[i], ".de"}, 64'(o.de), 64'(e.de));
      chk({nm[i], ".line_start"}, 64'(o.ls), 64'(e.ls));
      chk({nm[i], ".frame_start"}, 64'(o.fs), 64'(e.fs));
      chk({nm[i], ".frame_ctr"}, 64'(o.fc), 64'(e.fc));
    end
  endtask

  task automatic step_model();
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      e = model(i);
      mls[i] = e.pce && e.h == 12'(ht(i) - 1);
      mfs[i] = mls[i] && e.v == 12'(vt(i) - 1);
      if (en) mc[i]++;
    end
  endtask

  // asynchronous assert mid-cycle, checked before any clock edge; ends 1 unit after a posedge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0;
      mls[i] = 1'b0;
      mfs[i] = 1'b0;
    end
    check_all();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic int sig(int sel);
    case (sel)
      0: return int'(hs_a);
      1: return int'(ls_a);
      default: return int'(hpos_a);
    endcase
  endfunction

  task automatic wait_for(input int sel, input int val, input int budget, input string name);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sig(sel) == val) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout after %0d clocks", name, budget);
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    longint c0, tf, ls1;
    int de_cnt, v1;
    cfg[0] = '{2, 640, 16, 96, 48, 400, 12, 2, 36, 2, 0, 0};
    cfg[1] = '{3, 16, 4, 6, 4, 6, 2, 2, 2, 3, 0, 1};
    cfg[2] = '{1, 8, 2, 3, 1, 4, 1, 2, 1, 1, 1, 1};
    tv = '{
      '{1, 0, 0, 0, 0, 1, 0}, '{1, 1, 0, 0, 1, 1, 0}, '{1, 2, 0, 0, 1, 1, 0},
      '{1, 3, 0, 0, 1, 1, 0}, '{1, 4, 0, 0, 1, 1, 0}, '{0, 5, 0, 0, 1, 0, 0},
      '{1, 5, 0, 0, 1, 1, 0}, '{1, 6, 0, 0, 1, 1, 0}, '{1, 7, 0, 0, 1, 1, 0},
      '{1, 8, 0, 0, 1, 1, 0}, '{1, 9, 0, 0, 0, 1, 0}, '{1, 10, 0, 0, 0, 1, 0},
      '{1, 11, 0, 1, 0, 1, 0}, '{1, 12, 0, 1, 0, 1, 0}, '{1, 13, 0, 1, 0, 1, 0},
      '{1, 0, 1, 0, 0, 1, 1}, '{1, 1, 1, 0, 1, 1, 0}
    };
    en = 1'b1;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      en = tv[k].en != 0;
      @(negedge clk);
      chk($sformatf("C.tab%0d.hpos", k), 64'(hpos_c), 64'(tv[k].h));
      chk($sformatf("C.tab%0d.vpos", k), 64'(vpos_c), 64'(tv[k].v));
      chk($sformatf("C.tab%0d.hsync", k), 64'(hs_c), 64'(tv[k].hs));
      chk($sformatf("C.tab%0d.vsync", k), 64'(vs_c), 64'(0));
      chk($sformatf("C.tab%0d.de", k), 64'(de_c), 64'(tv[k].de));
      chk($sformatf("C.tab%0d.pix_ce", k), 64'(pce_c), 64'(tv[k].pce));
      chk($sformatf("C.tab%0d.line_start", k), 64'(ls_c), 64'(tv[k].ls));
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    do_reset();
    c0 = cyc;
    @(negedge clk);
    chk("A.pix_ce0", 64'(pce_a), 64'(0));
    @(negedge clk);
    chk("A.pix_ce1", 64'(pce_a), 64'(1));
    @(negedge clk);
    chk("A.pix_ce2", 64'(pce_a), 64'(0));
    wait_for(2, 656, 3000, "A.wait_hpos656");
    chk("A.hpos656_time", 64'(cyc - c0), 64'(1312));
    wait_for(0, 0, 100, "A.wait_hs_fall");
    chk("A.hs_fall_time", 64'(cyc - c0), 64'(1316));
    tf = cyc;
    wait_for(0, 1, 400, "A.wait_hs_rise");
    chk("A.hs_width", 64'(cyc - tf), 64'(192));
    wait_for(0, 0, 2000, "A.wait_hs_fall2");
    chk("A.hs_period", 64'(cyc - tf), 64'(1600));
    de_cnt = 0;
    for (int n = 0; n < 1600; n++) begin
      @(negedge clk);
      if (de_a) de_cnt++;
    end
    chk("A.de_per_line", 64'(de_cnt), 64'(1280));
    wait_for(1, 1, 2000, "A.wait_ls1");
    ls1 = cyc;
    v1 = int'(vpos_a);
    wait_for(0, 0, 2000, "A.wait_hs_fall3");
    tf = cyc;
    wait_for(2, 680, 200, "A.wait_hpos680");
    en = 1'b0;
    repeat (37) @(negedge clk);
    chk("A.stall_hold_hpos", 64'(hpos_a), 64'(680));
    chk("A.stall_hold_pix_ce", 64'(pce_a), 64'(0));
    en = 1'b1;
    wait_for(0, 1, 400, "A.wait_hs_rise_stall");
    chk("A.hs_width_stall", 64'(cyc - tf), 64'(229));
    wait_for(1, 1, 2000, "A.wait_ls2");
    chk("A.ls_spacing_stall", 64'(cyc - ls1), 64'(1637));
    chk("A.vpos_after_stall", 64'(vpos_a), 64'(v1 + 1));
    do_reset();
    for (int n = 0; n < 40000; n++) begin
      en = $urandom_range(0, 9) != 0;
      @(negedge clk);
      check_all();
      if (n < 10000 && (n == 3001 || $urandom_range(0, 1999) == 0)) begin
        do_reset();
        continue;
      end
      @(posedge clk);
      step_model();
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
